// File: rtl/switches_seq.sv
// Switch-sequence bomb module: the player sets the switches to N_STEPS target patterns in order.
// Optional input debouncing is enabled by defining SWITCHES_DEBOUNCE_EN.
module switches_seq #(
  parameter logic [3:0] MODULE_ADDRESS  = 4'd0,
  parameter int         N_SW            = 6,
  parameter int         N_STEPS         = 4,
  parameter int         VER_W           = 2,
  // Entry (v,s) sits at bit (v*N_STEPS+s)*N_SW; listed from v3/s3 down to v0/s0.
  parameter logic [(2**VER_W)*N_STEPS*N_SW-1:0] COND_TABLE = {
    6'b011110, 6'b001001, 6'b000001, 6'b100001,
    6'b111111, 6'b000100, 6'b010100, 6'b010000,
    6'b110000, 6'b100011, 6'b000011, 6'b000001,
    6'b101011, 6'b100000, 6'b010010, 6'b001000},
  parameter int         DEBOUNCE_CYCLES = 270000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [3:0]                       enable,
  input  logic [3:0]                       rng_output,
  input  logic [N_SW-1:0]                  switches,
  output logic                             strike,
  output logic                             module_defused,
  output logic [VER_W-1:0]                 version,
  output logic                             rng_enable,
  output logic [$clog2(N_STEPS+1)-1:0]     step
);

  localparam int STEP_W = $clog2(N_STEPS+1);
  localparam int N_ENT  = (2**VER_W) * N_STEPS;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS-1);

  typedef enum logic [2:0] {IDLE, SETUP, LATCH, ARMED, DEFUSED} state_t;

  state_t            state, state_next;
  logic [N_SW-1:0]   sw_meta, sw_sync, sw_s, sw_prev;
  logic [N_SW-1:0]   target, bad;
  logic [VER_W-1:0]  version_next;
  logic [STEP_W-1:0] step_next;
  logic              strike_pend, pend_next;
  logic              active;
  logic              unused_rng;

  // Only the low VER_W bits of the shared RNG select a version.
  assign unused_rng = ^rng_output;

  // NOTE: non-blocking assignments so every flop samples pre-edge values and the chain shifts one stage per edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

`ifdef SWITCHES_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES-1);

  logic [N_SW-1:0]  sw_cand, sw_deb;
  logic [CNT_W-1:0] stable_cnt;

  // Any change of the synchronised value restarts the stability count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_cand    <= '0;
      sw_deb     <= '0;
      stable_cnt <= '0;
    end else if (sw_sync != sw_cand) begin
      sw_cand    <= sw_sync;
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_MAX) begin
      sw_deb <= sw_cand;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign sw_s = sw_deb;
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;
  assign sw_s = sw_sync;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sw_prev <= '0;
    else       sw_prev <= sw_s;
  end

  assign active = (enable == MODULE_ADDRESS);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    target = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (i == int'(version) * N_STEPS + int'(step)) target = COND_TABLE[i*N_SW +: N_SW];
    end
  end

  // A toggle is wrong when the bit just moved and now disagrees with the target.
  assign bad = (sw_s ^ sw_prev) & (sw_s ^ target);

  always_comb begin
    state_next   = state;
    version_next = version;
    step_next    = step;
    pend_next    = 1'b0;
    case (state)
      IDLE:  if (active) state_next = SETUP;
      SETUP: state_next = LATCH;
      LATCH: begin
        version_next = rng_output[VER_W-1:0];
        step_next    = '0;
        state_next   = ARMED;
      end
      ARMED: begin
        if (active) begin
          if (|bad) begin
            pend_next = 1'b1;
          end else if (sw_s == target) begin
            step_next = step + 1'b1;
            if (step == LAST_STEP) state_next = DEFUSED;
          end
        end
      end
      DEFUSED: state_next = DEFUSED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      version     <= '0;
      step        <= '0;
      strike_pend <= 1'b0;
      strike      <= 1'b0;
    end else begin
      state       <= state_next;
      version     <= version_next;
      step        <= step_next;
      strike_pend <= pend_next;
      strike      <= strike_pend;
    end
  end

  assign rng_enable     = (state == SETUP);
  assign module_defused = (state == DEFUSED);

endmodule
